// File: rtl/hni_txdat_arb_pkg.sv
// Shared types and defaults for the HNI TXDAT flit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: DAT flit width, default requester count and beat limit,
// and the arbiter FSM state encoding.
package hni_txdat_arb_pkg;

    localparam int CHIE_DAT_FLIT_WIDTH      = 64;
    localparam int HNI_TXDAT_ARB_NUM_REQ_DEF   = 4;
    localparam int HNI_TXDAT_ARB_MAX_BEATS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_WON = 2'd2
    } arb_state_e;

endpackage

// File: rtl/hni_txdat_arb_if.sv
// Requester and TXDAT-sender handshake bundle for the TXDAT arbiter.
// Latency: n/a (wires only).
// Backpressure: carried by req_ready and txdat_arb_rdy/txdat_arb_won.
//
// master: arbiter side (drives req_ready and the offered flit).
// slave : requesters plus TXDAT sender (drive valids, flits, rdy, won).
interface hni_txdat_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int FLIT_W  = 64
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*FLIT_W-1:0] req_flit;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      arb_txdat_valid;
    logic [FLIT_W-1:0]         arb_txdat_flit;
    logic                      txdat_arb_rdy;
    logic                      txdat_arb_won;

    modport master (
        input  req_valid, req_flit, req_last, txdat_arb_rdy, txdat_arb_won,
        output req_ready, arb_txdat_valid, arb_txdat_flit
    );

    modport slave (
        output req_valid, req_flit, req_last, txdat_arb_rdy, txdat_arb_won,
        input  req_ready, arb_txdat_valid, arb_txdat_flit
    );
endinterface

// File: rtl/hni_txdat_arb_rr_pick.sv
// Round-robin pick: first set request at or after ptr_i, wrapping.
// Latency: combinational.
// Backpressure: none.
//
// Ports: req_i request vector, ptr_i priority start index,
//        gnt_o one-hot grant (zero when no request).
module hni_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hni_txdat_arb.sv
// Round-robin arbiter granting one requester a locked multi-beat TXDAT slot.
// Latency: first beat offered 1 cycle after grant; 3 cycles/beat first, 2 after.
// Backpressure: holds flit while txdat_arb_rdy low; req_ready pulses on won.
//
// Ports: clk, rst (sync, active-high); bus (master modport) carries the
// requester valid/flit/last/ready vectors and the TXDAT valid/flit/rdy/won;
// arb_grant is the registered one-hot owner; arb_err is a sticky error flag.
module hni_txdat_arb
    import hni_txdat_arb_pkg::*;
#(
    parameter int HNI_TXDAT_ARB_NUM_REQ   = HNI_TXDAT_ARB_NUM_REQ_DEF,
    parameter int HNI_TXDAT_ARB_MAX_BEATS = HNI_TXDAT_ARB_MAX_BEATS_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    hni_txdat_arb_if.master                  bus,
    output logic [HNI_TXDAT_ARB_NUM_REQ-1:0] arb_grant,
    output logic                             arb_err
);

    localparam int N      = HNI_TXDAT_ARB_NUM_REQ;
    localparam int FLIT_W = CHIE_DAT_FLIT_WIDTH;
    localparam int PTR_W  = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W  = $clog2(HNI_TXDAT_ARB_MAX_BEATS) + 1;

    arb_state_e        state_q;
    logic [N-1:0]      grant_q;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic              err_q;
    logic [FLIT_W-1:0] flit_q;

    logic [N-1:0]      pick_gnt;
    logic [PTR_W-1:0]  gidx;
    logic [PTR_W-1:0]  rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_d;
    logic [FLIT_W-1:0] cur_flit;
    logic              cur_vld;
    logic              cur_last;
    logic              won_ok;
    logic              overrun;
    logic              release_txn;

    hni_rr_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) gidx = PTR_W'(i);
        end
    end

    // Everything the owner presents is steered from the registered grant.
    always_comb begin
        cur_vld     = |(bus.req_valid & grant_q);
        cur_last    = |(bus.req_last & grant_q);
        cur_flit    = bus.req_flit[int'(gidx)*FLIT_W +: FLIT_W];
        won_ok      = (state_q == ST_WAIT_WON) && bus.txdat_arb_won;
        beat_cnt_d  = beat_cnt_q + CNT_W'(1);
        // A transaction that hits the beat limit without last is cut off.
        overrun     = won_ok && !cur_last &&
                      (beat_cnt_d == CNT_W'(HNI_TXDAT_ARB_MAX_BEATS));
        release_txn = won_ok && (cur_last || overrun);
        rr_ptr_d    = (int'(gidx) == N - 1) ? '0 : gidx + PTR_W'(1);
    end

    // Consumption is tied to the won pulse, so only the owner ever sees ready.
    assign bus.req_ready       = won_ok ? grant_q : '0;
    assign bus.arb_txdat_valid = (state_q == ST_SEND) && cur_vld;
    assign bus.arb_txdat_flit  = (state_q == ST_SEND) ? cur_flit : flit_q;
    assign arb_grant           = grant_q;
    assign arb_err             = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            flit_q     <= '0;
        end else begin
            // A won with nothing outstanding is a sender protocol error.
            if (bus.txdat_arb_won && (state_q != ST_WAIT_WON)) err_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (|bus.req_valid) begin
                        grant_q <= pick_gnt;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.arb_txdat_valid && bus.txdat_arb_rdy) begin
                        flit_q  <= cur_flit;
                        state_q <= ST_WAIT_WON;
                    end
                end
                ST_WAIT_WON: begin
                    if (won_ok) begin
                        if (release_txn) begin
                            grant_q    <= '0;
                            beat_cnt_q <= '0;
                            rr_ptr_q   <= rr_ptr_d;
                            state_q    <= ST_IDLE;
                            if (overrun) err_q <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_d;
                            state_q    <= ST_SEND;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hni_txdat_arb.sv
// Directed per-cycle vector bench for hni_txdat_arb.
// Latency: n/a.
// Backpressure: driven explicitly by vectors (rdy, won).
module tb_hni_txdat_arb;
    import hni_txdat_arb_pkg::*;

    localparam int NR = 4;
    localparam int FW = CHIE_DAT_FLIT_WIDTH;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] last;
        logic       rdy;
        logic       won;
        logic [31:0] fl;      // byte i = low byte of requester i flit
        logic [3:0] e_grant;
        logic       e_txv;
        logic [7:0] e_flit;
        logic [3:0] e_ready;
        logic       e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0] arb_grant;
    logic          arb_err;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_mis = 0;

    hni_txdat_arb_if #(.NUM_REQ(NR), .FLIT_W(FW)) bus ();

    hni_txdat_arb #(
        .HNI_TXDAT_ARB_NUM_REQ   (NR),
        .HNI_TXDAT_ARB_MAX_BEATS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .arb_grant (arb_grant),
        .arb_err   (arb_err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] vld, input logic [3:0] last,
                       input logic rdy, input logic won, input logic [31:0] fl,
                       input logic [3:0] eg, input logic etv, input logic [7:0] ef,
                       input logic [3:0] erd, input logic eerr);
        vec_t v;
        v.rst = r; v.vld = vld; v.last = last; v.rdy = rdy; v.won = won; v.fl = fl;
        v.e_grant = eg; v.e_txv = etv; v.e_flit = ef; v.e_ready = erd; v.e_err = eerr;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        logic [NR*FW-1:0] f;
        f = '0;
        for (int i = 0; i < NR; i++) f[i*FW +: 8] = v.fl[i*8 +: 8];
        rst               = v.rst;
        bus.req_valid     = v.vld;
        bus.req_last      = v.last;
        bus.req_flit      = f;
        bus.txdat_arb_rdy = v.rdy;
        bus.txdat_arb_won = v.won;
    endtask

    task automatic check(input int n, input vec_t v);
        logic [FW-1:0] ef;
        ef = FW'(v.e_flit);
        n_vec++;
        if (arb_grant !== v.e_grant) begin
            n_mis++;
            $display("FAIL v%0d grant: got %b want %b", n, arb_grant, v.e_grant);
        end
        if (bus.arb_txdat_valid !== v.e_txv) begin
            n_mis++;
            $display("FAIL v%0d txdat_valid: got %b want %b", n, bus.arb_txdat_valid, v.e_txv);
        end
        if (bus.arb_txdat_flit !== ef) begin
            n_mis++;
            $display("FAIL v%0d txdat_flit: got %h want %h", n, bus.arb_txdat_flit, ef);
        end
        if (bus.req_ready !== v.e_ready) begin
            n_mis++;
            $display("FAIL v%0d req_ready: got %b want %b", n, bus.req_ready, v.e_ready);
        end
        if (arb_err !== v.e_err) begin
            n_mis++;
            $display("FAIL v%0d arb_err: got %b want %b", n, arb_err, v.e_err);
        end
    endtask

    initial begin
        logic [31:0] F;
        logic [31:0] fc;
        logic [7:0]  prev;
        logic [7:0]  fk;
        logic [7:0]  fb;
        logic [3:0]  oh;
        logic [3:0]  lst;
        int          ord [6];

        F   = 32'h30_20_A1_10;
        ord = '{3, 0, 1, 2, 3, 0};

        // Reset state
        add(1, 4'b0000, 4'b0000, 0, 0, F, 4'b0000, 0, 8'h00, 4'b0000, 0);

        // Reqs 0 and 2, single beat each: order 0 then 2
        add(0, 4'b0101, 4'b0101, 1, 0, F, 4'b0000, 0, 8'h00, 4'b0000, 0);
        add(0, 4'b0101, 4'b0101, 1, 0, F, 4'b0001, 1, 8'h10, 4'b0000, 0);
        add(0, 4'b0101, 4'b0101, 1, 1, F, 4'b0001, 0, 8'h10, 4'b0001, 0);
        add(0, 4'b0100, 4'b0100, 1, 0, F, 4'b0000, 0, 8'h10, 4'b0000, 0);
        add(0, 4'b0100, 4'b0100, 1, 0, F, 4'b0100, 1, 8'h20, 4'b0000, 0);
        add(0, 4'b0100, 4'b0100, 1, 1, F, 4'b0100, 0, 8'h20, 4'b0100, 0);

        // All four valid: pointer now 3, then rotation 0,1,2,3,0
        prev = 8'h20;
        for (int j = 0; j < 6; j++) begin
            oh = 4'b0001 << ord[j];
            fk = F[ord[j]*8 +: 8];
            add(0, 4'b1111, 4'b1111, 1, 0, F, 4'b0000, 0, prev, 4'b0000, 0);
            add(0, 4'b1111, 4'b1111, 1, 0, F, oh,      1, fk,   4'b0000, 0);
            add(0, 4'b1111, 4'b1111, 1, 1, F, oh,      0, fk,   oh,      0);
            prev = fk;
        end

        // Req1 four-beat burst A1..A4 while req0 waits
        add(0, 4'b0011, 4'b0001, 1, 0, F, 4'b0000, 0, 8'h10, 4'b0000, 0);
        for (int b = 1; b <= 4; b++) begin
            fb  = 8'hA0 + 8'(b);
            fc  = {8'h30, 8'h20, fb, 8'h10};
            lst = (b == 4) ? 4'b0011 : 4'b0001;
            add(0, 4'b0011, lst, 1, 0, fc, 4'b0010, 1, fb, 4'b0000, 0);
            add(0, 4'b0011, lst, 1, 1, fc, 4'b0010, 0, fb, 4'b0010, 0);
        end
        add(0, 4'b0001, 4'b0001, 1, 0, F, 4'b0000, 0, 8'hA4, 4'b0000, 0);
        add(0, 4'b0001, 4'b0001, 1, 0, F, 4'b0001, 1, 8'h10, 4'b0000, 0);
        add(0, 4'b0001, 4'b0001, 1, 1, F, 4'b0001, 0, 8'h10, 4'b0001, 0);

        // Req3 with sender backpressure for 5 cycles, then a valid drop
        add(0, 4'b1000, 4'b1000, 0, 0, F, 4'b0000, 0, 8'h10, 4'b0000, 0);
        for (int c = 0; c < 5; c++)
            add(0, 4'b1000, 4'b1000, 0, 0, F, 4'b1000, 1, 8'h30, 4'b0000, 0);
        add(0, 4'b0000, 4'b1000, 1, 0, F, 4'b1000, 0, 8'h30, 4'b0000, 0);
        add(0, 4'b1000, 4'b1000, 1, 0, F, 4'b1000, 1, 8'h30, 4'b0000, 0);
        add(0, 4'b1000, 4'b1000, 1, 1, F, 4'b1000, 0, 8'h30, 4'b1000, 0);

        // Req2 never asserts last: forced release after the 4th won
        add(0, 4'b0100, 4'b0000, 1, 0, F, 4'b0000, 0, 8'h30, 4'b0000, 0);
        for (int b = 1; b <= 4; b++) begin
            add(0, 4'b0100, 4'b0000, 1, 0, F, 4'b0100, 1, 8'h20, 4'b0000, 0);
            add(0, 4'b0100, 4'b0000, 1, 1, F, 4'b0100, 0, 8'h20, 4'b0100, 0);
        end
        add(0, 4'b0100, 4'b0000, 1, 0, F, 4'b0000, 0, 8'h20, 4'b0000, 1);
        add(0, 4'b0100, 4'b0000, 1, 0, F, 4'b0100, 1, 8'h20, 4'b0000, 1);

        // Reset while in WAIT_WON, then a stray won right after reset
        add(1, 4'b0100, 4'b0000, 1, 0, F, 4'b0100, 0, 8'h20, 4'b0000, 1);
        add(0, 4'b0000, 4'b0000, 0, 1, F, 4'b0000, 0, 8'h00, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, F, 4'b0000, 0, 8'h00, 4'b0000, 1);
        add(0, 4'b0000, 4'b0000, 0, 0, F, 4'b0000, 0, 8'h00, 4'b0000, 1);

        // Apply: inputs just after the rising edge, outputs on the falling edge
        rst               = 1'b1;
        bus.req_valid     = '0;
        bus.req_last      = '0;
        bus.req_flit      = '0;
        bus.txdat_arb_rdy = 1'b0;
        bus.txdat_arb_won = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < vq.size(); n++) begin
            drive(vq[n]);
            @(negedge clk);
            check(n, vq[n]);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/hni_txdat_arb.md
HNI_TXDAT_ARB -- requirements
Module: hni_txdat_arb

Interface
REQ-001 The module SHALL declare parameter HNI_TXDAT_ARB_NUM_REQ, default 4, number of data requesters sharing the TXDAT flit path.
REQ-002 The module SHALL declare parameter HNI_TXDAT_ARB_MAX_BEATS, default 4, maximum data beats per transaction.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester beat-valid; held with its flit until req_ready.
REQ-006 req_flit  input  NUM_REQ*`CHIE_DAT_FLIT_WIDTH  per-requester DAT flit, requester i at slice i.
REQ-007 req_last  input  NUM_REQ  per-requester final-beat marker.
REQ-008 req_ready  output  NUM_REQ  one-cycle pulse: the current beat of requester i is consumed.
REQ-009 arb_txdat_valid  output  1  flit offered to the TXDAT sender.
REQ-010 arb_txdat_flit  output  `CHIE_DAT_FLIT_WIDTH  offered flit.
REQ-011 txdat_arb_rdy  input  1  sender has credit and samples the flit this cycle if valid.
REQ-012 txdat_arb_won  input  1  pulse one cycle after sampling; the beat is sent.
REQ-013 arb_grant  output  NUM_REQ  registered one-hot owner; zero when idle.
REQ-014 arb_err  output  1  sticky protocol-error flag.

Function
REQ-015 The FSM SHALL have three states: IDLE, SEND, WAIT_WON.
REQ-016 In IDLE with any req_valid set, the block SHALL grant the first valid requester at or after rr_ptr (wrapping), load arb_grant, and enter SEND next cycle.
REQ-017 In SEND, arb_txdat_valid SHALL equal req_valid of the granted requester, and arb_txdat_flit SHALL be its flit, combinationally from the registered grant.
REQ-018 In SEND with arb_txdat_valid and txdat_arb_rdy both high, the FSM SHALL enter WAIT_WON; otherwise it SHALL stay in SEND.
REQ-019 In WAIT_WON, arb_txdat_valid SHALL be 0 and arb_txdat_flit SHALL hold its last value.
REQ-020 On txdat_arb_won in WAIT_WON, req_ready of the granted requester SHALL pulse in that same cycle, and beat_cnt SHALL increment.
REQ-021 If req_last of the granted requester is high on that won cycle, the block SHALL clear arb_grant and beat_cnt, set rr_ptr to grant index+1 mod NUM_REQ, and enter IDLE. Otherwise it SHALL return to SEND with the grant held.
REQ-022 The grant SHALL be locked for the whole transaction; no other requester is served until last.
REQ-023 Throughput SHALL be one beat per 3 cycles best case (IDLE->SEND->WAIT_WON) for the first beat, and one beat per 2 cycles for later beats.
REQ-024 beat_cnt SHALL be clog2(MAX_BEATS)+1 bits wide. If it reaches MAX_BEATS without last, arb_err SHALL set, and the block SHALL force release as if last.
REQ-025 txdat_arb_won outside WAIT_WON SHALL set arb_err and otherwise be ignored.
REQ-026 A granted requester dropping req_valid in SEND SHALL stall the FSM in SEND, with no error and no grant change.
REQ-027 rr_ptr SHALL wrap from NUM_REQ-1 to 0.
REQ-028 With only one requester active, it SHALL be regranted back-to-back.
REQ-029 req_ready SHALL never be asserted to a non-granted requester, and SHALL be asserted for at most one requester per cycle.

Reset
REQ-030 rst SHALL put the FSM in IDLE and clear rr_ptr, arb_grant, beat_cnt, arb_err, req_ready, arb_txdat_valid and arb_txdat_flit to 0.
REQ-031 rst mid-transaction SHALL abandon the transaction with no req_ready pulse. A txdat_arb_won in the first cycle after reset SHALL be flagged per REQ-025.

Structure
REQ-032 NUM_REQ, MAX_BEATS defaults and the FSM state encodings (IDLE=2'd0, SEND=2'd1, WAIT_WON=2'd2) SHALL live in hni_defines.v / hni_param.v.
REQ-033 The round-robin priority pick SHALL be one sub-module, hni_rr_pick, with a request vector and pointer in and a one-hot grant out.
REQ-034 hni_rr_pick SHALL be purely combinational.

Verification
REQ-035 Scenario: reqs 0 and 2 each send a single beat with last=1, rdy held 1, won one cycle after sample. Required: order 0 then 2, rr_ptr=3 at end, 2 req_ready pulses, arb_err=0.
REQ-036 Scenario: all 4 requesters continuously valid with 1-beat transactions. Required: grants cycle 0,1,2,3,0 with no starvation.
REQ-037 Scenario: req1 sends 4 beats, last on beat 4, while req0 is also valid. Required: req0 is not served until req1's 4th won; beat order is preserved; flits match the driven values 0xA1..0xA4.
REQ-038 Scenario: rdy=0 for 5 cycles during SEND. Required: valid and the same flit are held for all 5 cycles; req_ready is not pulsed; the transfer completes after rdy rises.
REQ-039 Scenario: a 5th beat is driven without last (MAX_BEATS=4). Required: arb_err=1 after the 4th won, grant is released, and arb_err stays set until rst.
REQ-040 Scenario: rst asserted while in WAIT_WON, then won pulses. Required: all outputs are 0 after reset, arb_err=1, and no req_ready pulse.
